delay_prog_ctrl: RTL and testbench
==================================

// Module: delay_prog_ctrl
// PURPOSE
//  Programs the PCM delay line on behalf of two requesters: host register path and auto-calibration.
//  Round-robin arbitration picks one request; the block then drives the active-low prog_ctl_ strobe
//  and prog_delay, and mutes downstream audio while the new tap settles.
//  It acknowledges the winner when the new delay is in effect. Sits between the config/cal logic
//  and the delay line.
// PARAMETERS
//  D_DEPTH  3  width of delay value (taps 0..2**D_DEPTH-1)
//  SETTLE   8  mute cycles after new delay takes effect; must be >=1
// PORTS
//  clk         in   1        single clock; all logic posedge clk
//  rst         in   1        synchronous, active-high reset
//  h_req       in   1        host request; held until h_ack
//  h_delay     in   D_DEPTH  host requested delay; stable while h_req=1
//  h_ack       out  1        one-cycle pulse: host request completed
//  c_req       in   1        calibration request; held until c_ack
//  c_delay     in   D_DEPTH  cal requested delay; stable while c_req=1
//  c_ack       out  1        one-cycle pulse: cal request completed
//  prog_ctl_   out  1        active-low program strobe to delay line
//  prog_delay  out  D_DEPTH  delay value to delay line; valid while prog_ctl_=0, held after
//  mute        out  1        1 = downstream must zero/ignore delay line output
//  busy        out  1        1 = state != IDLE
//  cur_delay   out  D_DEPTH  delay currently programmed in the line
// BEHAVIOUR
//  - All outputs registered. Reset (rst=1 at edge): state=IDLE, prog_ctl_=1, prog_delay=0, mute=0,
//    h_ack=c_ack=0, busy=0, cur_delay=0, cnt=0, last_gnt=CAL (host wins first tie).
//  - FSM states: IDLE, PROG, FLUSH, DONE.
//    IDLE: no req -> stay. Winner chosen, delay latched into sel_delay/sel_src.
//      If sel_delay==cur_delay -> DONE (shortcut); else -> PROG.
//    PROG: prog_ctl_=0, prog_delay=sel_delay for exactly 1 cycle; cur_delay<=sel_delay at its
//      ending edge (same edge the line captures it). Next state is FLUSH, with cnt<=SETTLE-1.
//    FLUSH: mute=1; cnt decrements; at cnt==0 -> DONE.
//    DONE: ack of sel_src =1 for 1 cycle; last_gnt<=sel_src; -> IDLE.
//  - Arbitration only in IDLE. Single req wins. Both req: grant the source != last_gnt.
//  - Timing, with req sampled high in IDLE cycle n:
//    prog_ctl_=0 in n+1; mute=1 in n+2..n+1+SETTLE; ack in n+2+SETTLE.
//  - Shortcut timing: ack in n+1; prog_ctl_ stays 1; mute stays 0; cur_delay unchanged.
//  - Requester must drop req at the edge ending its ack cycle. IDLE is at least 1 cycle between
//    grants. A req held past that edge is treated as a new request.
//  - Req changes while not IDLE are ignored; the latched sel_delay is used.
//  - rst mid-operation (any state): abandon at once, return to reset values, no ack.
//    A still-held req is re-arbitrated from IDLE.
//  - prog_delay and cur_delay are never written outside PROG or reset. Counter width is
//    $clog2(SETTLE+1); no wrap.
// STRUCTURE
//  - Package delay_ctrl_pkg holds: state enum {IDLE,PROG,FLUSH,DONE}, source enum {SRC_HOST,SRC_CAL},
//    D_DEPTH default, SETTLE default.
//  - Sub-module rr_arb2: 2-way round-robin, inputs req[1:0]/last_gnt, output gnt onehot.
//    Combinational; last_gnt register stays in parent.
//  - Top holds FSM, sel latch, settle counter, output registers.
// TESTING
//  1. rst=1 for 3 cycles with both req=1 -> all outputs at reset values; no ack during or right after.
//  2. h_req, h_delay=5, cur=0 -> prog_ctl_=0 / prog_delay=5 in n+1; mute in n+2..n+9;
//     h_ack in n+10; cur_delay=5.
//  3. Right after reset, h_req(3) and c_req(6) together -> host first (h_ack n+10), cal next
//     (prog_delay=6); a following tie -> host.
//  4. cur=5, c_req with c_delay=5 -> c_ack in n+1; prog_ctl_ stays 1; mute stays 0.
//  5. rst pulsed in 4th FLUSH cycle of a host req -> next cycle mute=0, busy=0, cur_delay=0, no h_ack.
//     Held h_req is re-serviced with full timing.
//  6. c_delay changed mid-FLUSH from 2 to 7 -> prog_delay and cur_delay stay 2; c_ack on schedule.

Source files
------------

// File: rtl/delay_prog_ctrl_pkg.sv
// Shared types and defaults for the PCM delay-line programming controller.
//   state_e : controller FSM states (also exported on the debug state output)
//   src_e   : requester identity; its encoding is also the bit index used in the
//             arbiter request/grant vectors (bit 0 = host, bit 1 = calibration)
package delay_ctrl_pkg;

  localparam int D_DEPTH_DEF = 3;  // delay value width (taps 0..2**D_DEPTH-1)
  localparam int SETTLE_DEF  = 8;  // mute cycles after a new tap takes effect

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROG  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_CAL  = 1'b1
  } src_e;

endpackage

// File: rtl/delay_prog_ctrl_if.sv
// Bundle between the requesters (host register path, auto-calibration) and the
// delay-line programming controller, plus the delay-line side outputs.
//
// Handshake: a requester raises x_req with x_delay stable and holds both until
// it sees the one-cycle x_ack pulse; it must drop x_req at the clock edge that
// ends the ack cycle. A request still high after that edge is a new request.
//
//   master : requester / environment side (drives h_req/h_delay/c_req/c_delay)
//   slave  : controller side (drives acks, delay-line strobe/value, mute, status)
interface delay_prog_ctrl_if
  import delay_ctrl_pkg::*;
#(
  parameter int D_DEPTH = D_DEPTH_DEF
);
  logic               h_req;
  logic [D_DEPTH-1:0] h_delay;
  logic               h_ack;
  logic               c_req;
  logic [D_DEPTH-1:0] c_delay;
  logic               c_ack;
  logic               prog_ctl_;   // active-low program strobe
  logic [D_DEPTH-1:0] prog_delay;
  logic               mute;
  logic               busy;
  logic [D_DEPTH-1:0] cur_delay;
  state_e             dbg_state;   // controller FSM state, for observation only

  modport master (
    output h_req, h_delay, c_req, c_delay,
    input  h_ack, c_ack, prog_ctl_, prog_delay, mute, busy, cur_delay, dbg_state
  );

  modport slave (
    input  h_req, h_delay, c_req, c_delay,
    output h_ack, c_ack, prog_ctl_, prog_delay, mute, busy, cur_delay, dbg_state
  );
endinterface

// File: rtl/delay_prog_ctrl_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req[1:0]  in  request vector, bit index = src_e encoding
//   last_gnt  in  source granted most recently (register lives in the parent)
//   gnt[1:0]  out one-hot grant, zero when nothing is requested
// A lone request always wins; on a tie the source that did not win last time wins.
module rr_arb2
  import delay_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  src_e       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_gnt == SRC_CAL) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/delay_prog_ctrl.sv
// PCM delay-line programming controller.
// Arbitrates host and calibration requests, strobes the new tap into the delay
// line, mutes downstream audio while the tap settles, then acknowledges the
// requester once the new delay is in effect.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : delay_prog_ctrl_if.slave (requests/acks, prog_ctl_/prog_delay,
//              mute, busy, cur_delay, dbg_state); all outputs are registered
// Parameters: D_DEPTH delay width, SETTLE mute cycles (must be >= 1).
module delay_prog_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int D_DEPTH = D_DEPTH_DEF,
  parameter int SETTLE  = SETTLE_DEF
)(
  input  logic               clk,
  input  logic               rst,
  delay_prog_ctrl_if.slave   bus
);

  localparam int CW = $clog2(SETTLE + 1);

  state_e             state_q,      state_d;
  src_e               sel_src_q,    sel_src_d;
  src_e               last_gnt_q,   last_gnt_d;
  logic [D_DEPTH-1:0] sel_delay_q,  sel_delay_d;
  logic [CW-1:0]      cnt_q,        cnt_d;
  logic               prog_ctl_n_q, prog_ctl_n_d;
  logic [D_DEPTH-1:0] prog_delay_q, prog_delay_d;
  logic               mute_q,       mute_d;
  logic               h_ack_q,      h_ack_d;
  logic               c_ack_q,      c_ack_d;
  logic               busy_q,       busy_d;
  logic [D_DEPTH-1:0] cur_delay_q,  cur_delay_d;

  logic [1:0]         gnt;
  src_e               win_src;
  logic [D_DEPTH-1:0] win_delay;

  rr_arb2 u_arb (
    .req      ({bus.c_req, bus.h_req}),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );

  assign win_src   = gnt[SRC_CAL] ? SRC_CAL : SRC_HOST;
  assign win_delay = gnt[SRC_CAL] ? bus.c_delay : bus.h_delay;

  always_comb begin
    state_d      = state_q;
    sel_src_d    = sel_src_q;
    last_gnt_d   = last_gnt_q;
    sel_delay_d  = sel_delay_q;
    cnt_d        = cnt_q;
    prog_ctl_n_d = prog_ctl_n_q;
    prog_delay_d = prog_delay_q;
    mute_d       = mute_q;
    busy_d       = busy_q;
    cur_delay_d  = cur_delay_q;
    h_ack_d      = 1'b0;
    c_ack_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          sel_src_d   = win_src;
          sel_delay_d = win_delay;
          busy_d      = 1'b1;
          if (win_delay == cur_delay_q) begin
            // Tap already in place: acknowledge without touching the line.
            state_d = DONE;
            h_ack_d = (win_src == SRC_HOST);
            c_ack_d = (win_src == SRC_CAL);
          end else begin
            // Strobe and value are registered, so they are loaded on the edge
            // entering PROG and are visible for exactly the PROG cycle.
            state_d      = PROG;
            prog_ctl_n_d = 1'b0;
            prog_delay_d = win_delay;
          end
        end
      end
      PROG: begin
        // The line captures prog_delay on this edge, so the new tap is current now.
        state_d      = FLUSH;
        prog_ctl_n_d = 1'b1;
        cur_delay_d  = sel_delay_q;
        cnt_d        = CW'(SETTLE - 1);
        mute_d       = 1'b1;
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          mute_d  = 1'b0;
          h_ack_d = (sel_src_q == SRC_HOST);
          c_ack_d = (sel_src_q == SRC_CAL);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        last_gnt_d = sel_src_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_src_q    <= SRC_HOST;
      last_gnt_q   <= SRC_CAL;   // host wins the first tie
      sel_delay_q  <= '0;
      cnt_q        <= '0;
      prog_ctl_n_q <= 1'b1;
      prog_delay_q <= '0;
      mute_q       <= 1'b0;
      h_ack_q      <= 1'b0;
      c_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      cur_delay_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_src_q    <= sel_src_d;
      last_gnt_q   <= last_gnt_d;
      sel_delay_q  <= sel_delay_d;
      cnt_q        <= cnt_d;
      prog_ctl_n_q <= prog_ctl_n_d;
      prog_delay_q <= prog_delay_d;
      mute_q       <= mute_d;
      h_ack_q      <= h_ack_d;
      c_ack_q      <= c_ack_d;
      busy_q       <= busy_d;
      cur_delay_q  <= cur_delay_d;
    end
  end

  assign bus.h_ack      = h_ack_q;
  assign bus.c_ack      = c_ack_q;
  assign bus.prog_ctl_  = prog_ctl_n_q;
  assign bus.prog_delay = prog_delay_q;
  assign bus.mute       = mute_q;
  assign bus.busy       = busy_q;
  assign bus.cur_delay  = cur_delay_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_delay_prog_ctrl.sv
// Directed bench for delay_prog_ctrl: reset behaviour, full programming
// sequence timing, round-robin tie handling, same-tap shortcut, mid-operation
// reset and request changes while busy.
module tb_delay_prog_ctrl;
  import delay_ctrl_pkg::*;

  localparam int D_DEPTH = 3;
  localparam int SETTLE  = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  delay_prog_ctrl_if #(.D_DEPTH(D_DEPTH)) bus ();

  delay_prog_ctrl #(.D_DEPTH(D_DEPTH), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_prog_ctl"},   32'(bus.prog_ctl_),  32'd1);
    chk({tag, "_prog_delay"}, 32'(bus.prog_delay), 32'd0);
    chk({tag, "_mute"},       32'(bus.mute),       32'd0);
    chk({tag, "_h_ack"},      32'(bus.h_ack),      32'd0);
    chk({tag, "_c_ack"},      32'(bus.c_ack),      32'd0);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_cur_delay"},  32'(bus.cur_delay),  32'd0);
    chk({tag, "_state"},      32'(bus.dbg_state),  32'(IDLE));
  endtask

  // Called during IDLE cycle n with the winning request presented. Checks the
  // full sequence through the ack cycle, drops that request, and returns in the
  // following IDLE cycle. chg >= 0 changes c_delay to 7 after that FLUSH cycle.
  task automatic expect_full(input string tag, input src_e src, input int dly,
                             input int prev, input int chg);
    step();  // n+1
    chk({tag, "_prog_strobe"}, 32'(bus.prog_ctl_),  32'd0);
    chk({tag, "_prog_val"},    32'(bus.prog_delay), 32'(dly));
    chk({tag, "_prog_mute"},   32'(bus.mute),       32'd0);
    chk({tag, "_prog_busy"},   32'(bus.busy),       32'd1);
    chk({tag, "_prog_cur"},    32'(bus.cur_delay),  32'(prev));
    chk({tag, "_prog_acks"},   32'({bus.h_ack, bus.c_ack}), 32'd0);
    for (int i = 0; i < SETTLE; i++) begin  // n+2 .. n+1+SETTLE
      step();
      chk({tag, "_fl_mute"},  32'(bus.mute),       32'd1);
      chk({tag, "_fl_ctl"},   32'(bus.prog_ctl_),  32'd1);
      chk({tag, "_fl_pdly"},  32'(bus.prog_delay), 32'(dly));
      chk({tag, "_fl_cur"},   32'(bus.cur_delay),  32'(dly));
      chk({tag, "_fl_acks"},  32'({bus.h_ack, bus.c_ack}), 32'd0);
      if (i == chg) bus.c_delay = 3'd7;
    end
    step();  // n+2+SETTLE
    chk({tag, "_ack_h"},    32'(bus.h_ack),     32'(src == SRC_HOST));
    chk({tag, "_ack_c"},    32'(bus.c_ack),     32'(src == SRC_CAL));
    chk({tag, "_ack_mute"}, 32'(bus.mute),      32'd0);
    chk({tag, "_ack_cur"},  32'(bus.cur_delay), 32'(dly));
    if (src == SRC_HOST) bus.h_req = 1'b0;
    else                 bus.c_req = 1'b0;
    step();
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_acks"}, 32'({bus.h_ack, bus.c_ack}), 32'd0);
    chk({tag, "_idle_pdly"}, 32'(bus.prog_delay), 32'(dly));
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.h_req   = 1'b1;
    bus.h_delay = 3'd3;
    bus.c_req   = 1'b1;
    bus.c_delay = 3'd6;

    // Reset held 3 cycles with both requests high.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_vals("rst_hold");
    end
    rst = 1'b0;

    // Tie right after reset: host (3) first, then cal (6).
    expect_full("tie1_host", SRC_HOST, 3, 0, -1);
    expect_full("tie1_cal",  SRC_CAL,  6, 3, -1);

    // Second tie: last winner was cal, so host wins; cal then hits the shortcut.
    bus.h_delay = 3'd5;
    bus.h_req   = 1'b1;
    bus.c_delay = 3'd5;
    bus.c_req   = 1'b1;
    expect_full("tie2_host", SRC_HOST, 5, 6, -1);
    step();
    chk("short_c_ack", 32'(bus.c_ack),     32'd1);
    chk("short_h_ack", 32'(bus.h_ack),     32'd0);
    chk("short_ctl",   32'(bus.prog_ctl_), 32'd1);
    chk("short_mute",  32'(bus.mute),      32'd0);
    chk("short_cur",   32'(bus.cur_delay), 32'd5);
    chk("short_state", 32'(bus.dbg_state), 32'(DONE));
    bus.c_req = 1'b0;
    step();
    chk("short_idle_busy", 32'(bus.busy),  32'd0);
    chk("short_idle_ack",  32'(bus.c_ack), 32'd0);
    chk("short_idle_mute", 32'(bus.mute),  32'd0);

    // Reset during the 4th FLUSH cycle of a host request.
    bus.h_delay = 3'd1;
    bus.h_req   = 1'b1;
    step();
    chk("mid_prog_ctl", 32'(bus.prog_ctl_), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_fl_mute", 32'(bus.mute), 32'd1);
    end
    rst = 1'b1;
    step();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    expect_full("reservice", SRC_HOST, 1, 0, -1);

    // Plain host program 1 -> 5.
    bus.h_delay = 3'd5;
    bus.h_req   = 1'b1;
    expect_full("host5", SRC_HOST, 5, 1, -1);

    // Cal request whose delay changes mid-FLUSH; latched value must stick.
    bus.c_delay = 3'd2;
    bus.c_req   = 1'b1;
    expect_full("cal_chg", SRC_CAL, 2, 5, 3);
    chk("cal_chg_cur_final", 32'(bus.cur_delay), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
